// File: rtl/decimal_to_binary_encoder.sv
// Registered 10-to-4 encoder: one-hot decimal digit in, binary code out.
// Empty input clears valid; multi-hot input encodes the highest set index
// and raises err.
module decimal_to_binary_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [9:0]  Decimal,
    output logic [3:0]  Binary,
    output logic        valid,
    output logic        err
);

    localparam int unsigned DEC_W = 10;
    localparam int unsigned BIN_W = 4;
    localparam int unsigned CNT_W = 2;

    logic [CNT_W-1:0] count_c;
    logic [BIN_W-1:0] index_c;

    // Set-bit count, saturating at two (0 / 1 / many)
    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < DEC_W; i++) begin
            if (Decimal[i] && (count_c != CNT_W'(2))) begin
                count_c = count_c + CNT_W'(1);
            end
        end
    end

    // Priority encode: ascending scan so the highest set bit wins
    always_comb begin
        index_c = '0;
        for (int unsigned i = 0; i < DEC_W; i++) begin
            if (Decimal[i]) begin
                index_c = BIN_W'(i);
            end
        end
    end

    // Output registers: capture on enabled edges, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Binary <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
        end else if (en) begin
            Binary <= index_c;
            valid  <= (count_c != CNT_W'(0));
            err    <= (count_c == CNT_W'(2));
        end
    end

endmodule

// File: tb/tb_decimal_to_binary_encoder.sv
// Scoreboard bench for decimal_to_binary_encoder: the driver pushes the
// expected output state for every clock edge, the monitor pops and compares.
module tb_decimal_to_binary_encoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [9:0] Decimal;
    logic [3:0] Binary;
    logic       valid;
    logic       err;

    int checks   = 0;
    int failures = 0;

    // expected state packed as {binary[3:0], valid, err}
    logic [5:0] sb_q[$];
    logic [5:0] model_state;
    bit         stim_done = 0;

    decimal_to_binary_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .Decimal (Decimal),
        .Binary  (Binary),
        .valid   (valid),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: highest set bit via log2, population count for valid/err
    function automatic logic [5:0] ref_encode(input int unsigned raw);
        int unsigned v;
        int          ones;
        int          hi;
        v    = raw % 1024;
        ones = $countones(v);
        if (ones == 0) return 6'b0;
        hi = $clog2(v + 1) - 1;
        return {4'(hi), 1'b1, (ones > 1)};
    endfunction

    task automatic compare(input string name, input logic [5:0] exp);
        checks++;
        if ({Binary, valid, err} !== exp) begin
            failures++;
            $display("FAIL %s: got Binary=%0d valid=%0b err=%0b, expected Binary=%0d valid=%0b err=%0b",
                     name, Binary, valid, err, exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of stimulus and record what the next edge must produce
    task automatic drive(input bit e, input int unsigned raw);
        @(negedge clk);
        en      = e;
        Decimal = 10'(raw);
        if (e) model_state = ref_encode(raw);
        sb_q.push_back(model_state);
    endtask

    // Pulse reset between edges and check the asynchronous clear
    task automatic reset_pulse();
        @(negedge clk);
        en = 1'b0;
        #1 rst_n = 1'b0;
        #1 compare("async_reset", 6'b0);
        model_state = 6'b0;
        #1 rst_n = 1'b1;
        sb_q.push_back(model_state);
    endtask

    // Monitor: one expected entry per edge that the driver announced
    initial begin
        logic [5:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                compare("scoreboard", exp);
            end
        end
    end

    initial begin
        int unsigned pat;
        int unsigned sel;
        model_state = 6'b0;
        rst_n   = 1'b0;
        en      = 1'b1;
        Decimal = 10'h200;
        repeat (3) @(posedge clk);
        #1 compare("reset_hold", 6'b0);

        // release reset; first enabled edge samples 0x200 -> 9
        @(negedge clk);
        rst_n = 1'b1;
        model_state = ref_encode(32'h200);
        sb_q.push_back(model_state);

        // one-hot sweep with a mid-stream reset
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'd1 << k);
            if (k == 5) reset_pulse();
        end

        // empty and truncated input
        drive(1'b1, 0);
        drive(1'b1, 1024);
        drive(1'b1, 3072);

        // multi-hot
        drive(1'b1, 10'b00_0000_0011);
        drive(1'b1, 10'b10_0001_0000);
        drive(1'b1, 10'b11_1111_1111);

        // enable hold
        drive(1'b1, 8);
        for (int i = 0; i < 3; i++) drive(1'b0, 256);
        drive(1'b1, 256);
        drive(1'b0, 0);

        // randomized mix of one-hot, empty, multi-hot and wide values
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       pat = 32'd1 << $urandom_range(0, 9);
            else if (sel == 4) pat = 0;
            else if (sel == 5) pat = $urandom_range(0, 65535);
            else               pat = $urandom_range(0, 1023);
            drive(($urandom_range(0, 3) != 0), pat);
            if (i == 150) reset_pulse();
        end

        // drain, bounded
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        stim_done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL timeout: simulation did not complete, expected completion");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
            $fatal(1);
        end
    end

endmodule

// File: doc/decimal_to_binary_encoder.md
# decimal_to_binary_encoder

Registered 10-to-4 encoder. Converts a one-hot decimal digit (bit *k* set means digit *k*, 0–9) into its 4-bit binary code. It also flags empty and invalid multi-hot inputs. It sits between a one-hot digit source (keypad/selector logic) and binary datapaths; outputs are registered on a single clock.

## Interface
- No parameters; widths are fixed at 10 input lines and 4 output bits.
- clk  input  1  rising-edge clock for all registers.
- rst_n  input  1  reset, asynchronous, active-low; clears all outputs immediately on assertion.
- en  input  1  sample enable; when high, Decimal is encoded at the next rising edge; when low, all outputs hold.
- Decimal  input  10  one-hot decimal digit; bit k (0–9) represents digit k.
- Binary  output  4  registered binary code of the digit (0–9).
- valid  output  1  registered; high when the last sampled Decimal had at least one bit set.
- err  output  1  registered; high when the last sampled Decimal had more than one bit set.

## Operation
- Exactly one bit k set: Binary = k, valid = 1, err = 0.
  - 10'b00_0000_0001 → 0
  - 10'b00_0000_0010 → 1
  - …
  - 10'b10_0000_0000 → 9
- No bit set (10'b0): Binary = 4'd0, valid = 0, err = 0.
- Two or more bits set: priority encode to the highest set index. Binary = that index, valid = 1, err = 1.
- Binary never exceeds 9. Codes 10–15 are never produced.
- Count of set bits is computed combinationally, saturating at 2 (0 / 1 / ≥2). Priority encode is combinational from bit 9 down to bit 0.
- en = 0: Binary, valid and err keep their previous values; Decimal is ignored.
- No internal state beyond the three output registers; no state machine.
- Drivers feeding a value wider than 10 bits must truncate to bits [9:0]. For example, 1024 (bit 10) arrives as 10'b0 and is treated as empty.

## Timing
- Latency: one clock. Decimal sampled at rising edge *n* (with en = 1) appears on outputs after edge *n*, stable until the next enabled edge.
- Throughput: one new digit per cycle.
- Reset assertion (rst_n falling): Binary = 0, valid = 0, err = 0 immediately, independent of clk. This also applies mid-stream; any in-flight sample is discarded.
- Reset release: the first enabled rising edge after rst_n goes high samples normally. No extra flush cycles.
- en and Decimal must meet setup/hold to clk; there is no internal synchronizer.
- Decimal changing while en = 0 has no effect, including on the cycle en returns high. Only the value present at the enabled edge is used.
- Outputs are glitch-free: they change only on a clk edge or on reset assertion.

## Test plan
- Reset: hold rst_n = 0 with Decimal = 10'h200 and en = 1 → Binary = 0, valid = 0, err = 0. Release reset; after one edge Binary = 9, valid = 1.
- One-hot sweep: en = 1; apply Decimal = 1, 2, 4, 8, 16, 32, 64, 128, 256, 512, one per cycle → Binary = 0,1,2,…,9 each one cycle later. valid = 1 and err = 0 throughout.
- Empty / truncated input: Decimal = 10'b0 (including a 1024 stimulus truncated to 10 bits) → Binary = 0, valid = 0, err = 0.
- Multi-hot: Decimal = 10'b00_0000_0011 → Binary = 1, valid = 1, err = 1. Decimal = 10'b10_0001_0000 → Binary = 9, err = 1.
- Enable hold: load Decimal = 8 (Binary = 3). Drop en, apply Decimal = 256 for 3 cycles → Binary stays 3. Raise en → Binary = 8 one cycle later.
- Asynchronous mid-stream reset: during the sweep, pulse rst_n low between clock edges → outputs go to 0 before the next edge. Encoding resumes on the first edge after release.
